// File: rtl/prog_lut_pkg.sv
// Shared types for the programmable LUT function unit: FSM encoding and depth helper.
// The SWEEP state exists only when PROG_LUT_SWEEP_EN is defined.
package prog_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
`ifdef PROG_LUT_SWEEP_EN
    ST_SWEEP = 2'd3,
`endif
    ST_READY = 2'd2
  } state_e;

  function automatic int DEPTH(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/prog_lut_fn_if.sv
// Load/evaluate bus of prog_lut_fn; sweep signals appear only with PROG_LUT_SWEEP_EN.
// master = stimulus/control side, slave = the function unit.
interface prog_lut_fn_if #(
  parameter int N_IN = 3
);
  import prog_lut_pkg::*;

  localparam int LUT_DEPTH = DEPTH(N_IN);

  logic            load_start;
  logic            load_valid;
  logic            load_bit;
  logic            load_done;
  logic [N_IN-1:0] w;
  logic            eval_valid;
  logic            f;
  logic            f_valid;
  logic            busy;
`ifdef PROG_LUT_SWEEP_EN
  logic                 sweep_start;
  logic [LUT_DEPTH-1:0] sweep_sig;
  logic                 sweep_done;
`endif

  modport master (
    output load_start, load_valid, load_bit, w, eval_valid,
`ifdef PROG_LUT_SWEEP_EN
    output sweep_start,
    input  sweep_sig, sweep_done,
`endif
    input  load_done, f, f_valid, busy
  );

  modport slave (
    input  load_start, load_valid, load_bit, w, eval_valid,
`ifdef PROG_LUT_SWEEP_EN
    input  sweep_start,
    output sweep_sig, sweep_done,
`endif
    output load_done, f, f_valid, busy
  );

endinterface

// File: rtl/lut_shadow_reg.sv
// Shadow register filled bit by bit plus the live truth table it is copied into on commit.
// The bit written on the commit cycle is forwarded so the table sees the complete load.
module lut_shadow_reg #(
  parameter int DEPTH_P = 8,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               wr_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               bit_i,
  input  logic               commit_i,
  output logic [DEPTH_P-1:0] table_o
);

  logic [DEPTH_P-1:0] shadow_q, shadow_d;
  logic [DEPTH_P-1:0] table_q, table_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH_P; gi++) begin : g_bit
      always_comb begin
        shadow_d[gi] = shadow_q[gi];
        if (clr_i)
          shadow_d[gi] = 1'b0;
        else if (wr_i && (idx_i == IDX_W'(gi)))
          shadow_d[gi] = bit_i;
        table_d[gi] = commit_i ? shadow_d[gi] : table_q[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q[gi] <= 1'b0;
          table_q[gi]  <= 1'b0;
        end else begin
          shadow_q[gi] <= shadow_d[gi];
          table_q[gi]  <= table_d[gi];
        end
      end
    end
  endgenerate

  assign table_o = table_q;

endmodule

// File: rtl/prog_lut_fn.sv
// Programmable N_IN-input Boolean function with serially loaded truth table and registered evaluation.
// Define PROG_LUT_SWEEP_EN to add the table sweep (sweep_start/sweep_sig/sweep_done).
module prog_lut_fn
  import prog_lut_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = $clog2(2**N_IN) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_lut_fn_if.slave  bus
);

  localparam int LUT_DEPTH = DEPTH(N_IN);

  state_e                 state_q;
  logic [CNT_W-1:0]       idx_q;
  logic                   f_q;
  logic                   f_valid_q;
  logic                   load_done_q;
  logic [LUT_DEPTH-1:0]   table_w;
  logic                   last_idx;
  logic                   shadow_wr;
  logic                   shadow_clr;
  logic                   commit;
  logic                   in_load;
  logic                   load_entry_ok;
`ifdef PROG_LUT_SWEEP_EN
  logic [LUT_DEPTH-1:0]   sweep_sig_q;
  logic                   sweep_done_q;
`endif

  assign last_idx      = (idx_q == CNT_W'(LUT_DEPTH - 1));
  assign in_load       = (state_q == ST_LOAD);
  // load_start is honoured everywhere except during a sweep
  assign load_entry_ok = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_READY);
  assign shadow_clr    = bus.load_start && load_entry_ok;
  assign shadow_wr     = in_load && bus.load_valid && !bus.load_start;
  assign commit        = shadow_wr && last_idx;

  lut_shadow_reg #(
    .DEPTH_P (LUT_DEPTH),
    .IDX_W   (N_IN)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (shadow_clr),
    .wr_i     (shadow_wr),
    .idx_i    (idx_q[N_IN-1:0]),
    .bit_i    (bus.load_bit),
    .commit_i (commit),
    .table_o  (table_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      f_q          <= 1'b0;
      f_valid_q    <= 1'b0;
      load_done_q  <= 1'b0;
`ifdef PROG_LUT_SWEEP_EN
      sweep_sig_q  <= '0;
      sweep_done_q <= 1'b0;
`endif
    end else begin
      f_valid_q   <= 1'b0;
      load_done_q <= 1'b0;
`ifdef PROG_LUT_SWEEP_EN
      sweep_done_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.load_start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            idx_q <= '0;
          end else if (bus.load_valid) begin
            if (last_idx) begin
              state_q     <= ST_READY;
              idx_q       <= '0;
              load_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (bus.load_start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
`ifdef PROG_LUT_SWEEP_EN
          end else if (bus.sweep_start) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
`endif
          end else if (bus.eval_valid) begin
            f_q       <= table_w[bus.w];
            f_valid_q <= 1'b1;
          end
        end
`ifdef PROG_LUT_SWEEP_EN
        ST_SWEEP: begin
          sweep_sig_q[idx_q[N_IN-1:0]] <= table_w[idx_q[N_IN-1:0]];
          if (last_idx) begin
            state_q      <= ST_READY;
            idx_q        <= '0;
            sweep_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.f         = f_q;
  assign bus.f_valid   = f_valid_q;
  assign bus.load_done = load_done_q;
`ifdef PROG_LUT_SWEEP_EN
  assign bus.busy       = in_load || (state_q == ST_SWEEP);
  assign bus.sweep_sig  = sweep_sig_q;
  assign bus.sweep_done = sweep_done_q;
`else
  assign bus.busy       = in_load;
`endif

endmodule

// File: tb/tb_prog_lut_fn.sv
// Directed bench for prog_lut_fn (N_IN=3): reset, loads, abort/restart, mid-load reset and,
// with PROG_LUT_SWEEP_EN, the table sweep.
module tb_prog_lut_fn;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  prog_lut_fn_if #(.N_IN(3)) bus_if ();

  prog_lut_fn #(.N_IN(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
  endtask

  // Optional start pulse, then nbits serial bits of v (bit 0 first); load_done expected only on bit 7.
  task automatic load_seq(input logic [7:0] v, input int nbits, input bit start);
    if (start) begin
      bus_if.load_start = 1'b1;
      tick();
      bus_if.load_start = 1'b0;
      check("busy_after_start", 32'(bus_if.busy), 32'd1);
    end
    for (int i = 0; i < nbits; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_bit   = v[i];
      tick();
      check($sformatf("load_done_bit%0d", i), 32'(bus_if.load_done), (i == 7) ? 32'd1 : 32'd0);
    end
    bus_if.load_valid = 1'b0;
    bus_if.load_bit   = 1'b0;
  endtask

  task automatic eval1(input logic [2:0] wv, input logic exp_f);
    bus_if.w          = wv;
    bus_if.eval_valid = 1'b1;
    tick();
    check($sformatf("f_valid_w%0d", wv), 32'(bus_if.f_valid), 32'd1);
    check($sformatf("f_w%0d", wv), 32'(bus_if.f), 32'(exp_f));
  endtask

  initial begin
    logic [7:0] maj;
    n_vec = 0;
    n_err = 0;
    maj   = 8'b1110_1000;
    rst_n = 1'b0;
    bus_if.load_start = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_bit   = 1'b0;
    bus_if.w          = '0;
    bus_if.eval_valid = 1'b0;
`ifdef PROG_LUT_SWEEP_EN
    bus_if.sweep_start = 1'b0;
`endif

    // 1: reset state, eval ignored in IDLE
    #1;
    check("rst_f", 32'(bus_if.f), 32'd0);
    check("rst_f_valid", 32'(bus_if.f_valid), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_load_done", 32'(bus_if.load_done), 32'd0);
`ifdef PROG_LUT_SWEEP_EN
    check("rst_sweep_sig", 32'(bus_if.sweep_sig), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    bus_if.eval_valid = 1'b1;
    tick();
    check("idle_eval_f_valid", 32'(bus_if.f_valid), 32'd0);
    tick();
    check("idle_eval_f_valid2", 32'(bus_if.f_valid), 32'd0);
    bus_if.eval_valid = 1'b0;

    // 2: majority table, back-to-back evaluation of every input
    load_seq(maj, 8, 1'b1);
    check("busy_after_commit", 32'(bus_if.busy), 32'd0);
    for (int i = 0; i < 8; i++) eval1(3'(i), maj[i]);
    bus_if.eval_valid = 1'b0;
    tick();
    check("f_valid_drop", 32'(bus_if.f_valid), 32'd0);
    check("load_done_single", 32'(bus_if.load_done), 32'd0);

    // 3: load_start beats a same-cycle eval, aborted XOR load, reload 8'h69
    bus_if.load_start = 1'b1;
    bus_if.eval_valid = 1'b1;
    bus_if.w          = 3'd0;
    tick();
    bus_if.load_start = 1'b0;
    check("start_wins_f_valid", 32'(bus_if.f_valid), 32'd0);
    check("start_wins_busy", 32'(bus_if.busy), 32'd1);
    bus_if.eval_valid = 1'b0;
    load_seq(8'b1001_0110, 4, 1'b0);
    bus_if.eval_valid = 1'b1;
    tick();
    bus_if.eval_valid = 1'b0;
    check("busy_eval_f_valid", 32'(bus_if.f_valid), 32'd0);
    check("busy_f_hold", 32'(bus_if.f), 32'd1);
    load_seq(8'b0110_1001, 8, 1'b1);
    // table[7] of 8'b0110_1001 is bit 7 = 0; low entries differ from the aborted XOR bits
    eval1(3'b111, 1'b0);
    eval1(3'b000, 1'b1);
    eval1(3'b001, 1'b0);
    eval1(3'b011, 1'b1);
    bus_if.eval_valid = 1'b0;

    // 4: asynchronous reset in the middle of a load
    load_seq(8'hAA, 5, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus_if.busy), 32'd0);
    check("midrst_f", 32'(bus_if.f), 32'd0);
    check("midrst_f_valid", 32'(bus_if.f_valid), 32'd0);
    check("midrst_load_done", 32'(bus_if.load_done), 32'd0);
    tick();
    rst_n = 1'b1;
    bus_if.eval_valid = 1'b1;
    tick();
    bus_if.eval_valid = 1'b0;
    check("midrst_idle_eval", 32'(bus_if.f_valid), 32'd0);
    load_seq(8'hFF, 8, 1'b1);
    eval1(3'd2, 1'b1);
    bus_if.eval_valid = 1'b0;

`ifdef PROG_LUT_SWEEP_EN
    // 5: sweep after a majority load
    begin
      int  n;
      bit  seen;
      load_seq(maj, 8, 1'b1);
      bus_if.sweep_start = 1'b1;
      tick();
      bus_if.sweep_start = 1'b0;
      check("sweep_busy", 32'(bus_if.busy), 32'd1);
      bus_if.eval_valid = 1'b1;
      bus_if.w          = 3'd3;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
        tick();
        n++;
        check($sformatf("sweep_f_valid_c%0d", n), 32'(bus_if.f_valid), 32'd0);
        seen = bus_if.sweep_done;
      end
      check("sweep_done_cycles", 32'(n), 32'd8);
      check("sweep_sig", 32'(bus_if.sweep_sig), 32'hE8);
      check("sweep_ready_busy", 32'(bus_if.busy), 32'd0);
      tick();
      check("post_sweep_f_valid", 32'(bus_if.f_valid), 32'd1);
      check("post_sweep_f", 32'(bus_if.f), 32'd1);
      bus_if.eval_valid = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
